// File: rtl/paddle_pkg.sv
// Shared types, default constants and the charge-threshold helper for the paddle timer.
package paddle_pkg;

  localparam int unsigned DEF_CHANNELS   = 4;
  localparam int unsigned DEF_CNT_W      = 10;
  localparam int unsigned DEF_MIN_LINES  = 2;
  localparam int unsigned DEF_SPAN_LINES = 380;

  typedef enum logic [1:0] {
    DUMP    = 2'd0,
    CAPTURE = 2'd1,
    CHARGE  = 2'd2,
    FULL    = 2'd3
  } ch_state_e;

  // min_lines + ((pos * span_lines) >> 8), saturated to the cnt_w-bit maximum.
  function automatic int unsigned thr_calc(input logic [7:0]  pos,
                                           input int unsigned min_lines,
                                           input int unsigned span_lines,
                                           input int unsigned cnt_w);
    int unsigned prod;
    int unsigned sum;
    int unsigned max_v;
    prod  = 32'(pos) * span_lines;
    sum   = min_lines + (prod >> 8);
    max_v = (32'd1 << cnt_w) - 32'd1;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/paddle_charge_ch.sv
// One paddle channel: RC charge modelled as a scanline counter against a position threshold.
module paddle_charge_ch
  import paddle_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_LINES  = DEF_MIN_LINES,
  parameter int unsigned SPAN_LINES = DEF_SPAN_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_tick_i,
  input  logic       dump_i,
  input  logic       en_i,
  input  logic [7:0] pos_i,
  output logic       inpt_o,
  output logic       charging_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             inpt_q;
  logic [CNT_W:0]   cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CAPTURE;
      cnt_q   <= '0;
      thr_q   <= '0;
      inpt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      inpt_q  <= (state_d == FULL) & en_i;
    end
  end

  // Next state: dump overrides every other transition, including a same-cycle tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    if (dump_i) begin
      state_d = DUMP;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DUMP: state_d = CAPTURE;
        CAPTURE: begin
          thr_d   = CNT_W'(thr_calc(pos_i, MIN_LINES, SPAN_LINES, CNT_W));
          cnt_d   = '0;
          state_d = (thr_d == '0) ? FULL : CHARGE;
        end
        CHARGE: begin
          if (line_tick_i) begin
            cnt_d = cnt_inc[CNT_W] ? CNT_MAX : cnt_inc[CNT_W-1:0];
            if (cnt_inc >= {1'b0, thr_q}) state_d = FULL;
          end
        end
        FULL: state_d = FULL;
        default: state_d = CAPTURE;
      endcase
    end
  end

  assign inpt_o     = inpt_q;
  assign charging_c = (state_d == CHARGE);

endmodule

// File: rtl/paddle_charge_timer.sv
// Four-channel paddle pot timer producing the INPT0-3 bit-7 levels seen by the TIA.
module paddle_charge_timer
  import paddle_pkg::*;
#(
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_LINES  = DEF_MIN_LINES,
  parameter int unsigned SPAN_LINES = DEF_SPAN_LINES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_tick,
  input  logic                  dump,
  input  logic [CHANNELS-1:0]   en,
  input  logic [8*CHANNELS-1:0] pos,
  output logic [CHANNELS-1:0]   inpt,
  output logic                  busy
);

  logic [CHANNELS-1:0] charging_c;
  logic                busy_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    paddle_charge_ch #(
      .CNT_W      (CNT_W),
      .MIN_LINES  (MIN_LINES),
      .SPAN_LINES (SPAN_LINES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .line_tick_i (line_tick),
      .dump_i      (dump),
      .en_i        (en[g]),
      .pos_i       (pos[8*g +: 8]),
      .inpt_o      (inpt[g]),
      .charging_c  (charging_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= |charging_c;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_paddle_charge_timer.sv
// Directed bench for paddle_charge_timer: cycle table plus long-charge and reset sequences.
module tb_paddle_charge_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_tick;
  logic        dump;
  logic [3:0]  en;
  logic [31:0] pos;
  logic [3:0]  inpt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  paddle_charge_timer dut (
    .clk       (clk),
    .reset     (reset),
    .line_tick (line_tick),
    .dump      (dump),
    .en        (en),
    .pos       (pos),
    .inpt      (inpt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dump;
    logic       tick;
    logic [3:0] en;
    logic [3:0] exp_inpt;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // n scanline pulses, each followed by gap-1 idle cycles
  task automatic tick_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      line_tick = 1'b1;
      step();
      line_tick = 1'b0;
      for (int j = 1; j < gap; j++) step();
    end
  endtask

  task automatic dump_release();
    dump = 1'b1;
    step();
    dump = 1'b0;
    step();
    step();
  endtask

  initial begin
    //            dump  tick  en     inpt   busy
    tbl[0]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1}; // CAPTURE -> CHARGE
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1}; // cnt 1
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1}; // hold without tick
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0}; // 2nd tick completes
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0}; // FULL holds
    tbl[5]  = '{1'b0, 1'b0, 4'h5, 4'h5, 1'b0}; // en masks
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0}; // dump
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0}; // release with tick: ignored
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1}; // tick in CAPTURE ignored
    tbl[10] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0}; // 1-cycle dump
    tbl[13] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b0}; // dump beats completing tick
    tbl[17] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4'h7, 4'h7, 1'b0}; // en[3] low while charged
    tbl[22] = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b0}; // en[3] high: immediate

    reset     = 1'b1;
    line_tick = 1'b0;
    dump      = 1'b0;
    en        = 4'hF;
    pos       = 32'h0;
    step();
    step();
    reset = 1'b0;
    check("reset_inpt", inpt, 4'h0);
    check("reset_busy", 4'(busy), 4'h0);

    for (int i = 0; i < 23; i++) begin
      dump      = tbl[i].dump;
      line_tick = tbl[i].tick;
      en        = tbl[i].en;
      step();
      check($sformatf("vec%0d_inpt", i), inpt, tbl[i].exp_inpt);
      check($sformatf("vec%0d_busy", i), 4'(busy), 4'(tbl[i].exp_busy));
    end
    line_tick = 1'b0;

    // pos1 = 128 -> 192 lines, ticks every 10 cycles
    pos = 32'h0000_8000;
    dump_release();
    check("p128_busy_start", 4'(busy), 4'h1);
    tick_n(191, 10);
    check("p128_after191", inpt, 4'hD);
    check("p128_busy191", 4'(busy), 4'h1);
    tick_n(1, 1);
    check("p128_after192", inpt, 4'hF);
    check("p128_busy192", 4'(busy), 4'h0);

    // pos2 = 255 -> 380 lines; later pos changes are not sampled mid-charge
    pos = 32'h00FF_0000;
    dump_release();
    tick_n(50, 2);
    pos = 32'h0;
    tick_n(329, 2);
    check("p255_after379", inpt, 4'hB);
    check("p255_busy379", 4'(busy), 4'h1);
    tick_n(1, 2);
    check("p255_after380", inpt, 4'hF);
    dump = 1'b1;
    step();
    check("p255_dumped", inpt, 4'h0);
    dump = 1'b0;
    step();
    step();
    tick_n(1, 2);
    check("p0_new_tick1", inpt, 4'h0);
    tick_n(1, 2);
    check("p0_new_tick2", inpt, 4'hF);

    // reset at cnt=100 restarts from zero with the current pos
    pos = 32'h0000_0080;
    dump_release();
    tick_n(100, 2);
    check("mid_inpt", inpt, 4'hE);
    check("mid_busy", 4'(busy), 4'h1);
    reset = 1'b1;
    pos   = 32'h0;
    step();
    reset = 1'b0;
    check("mid_reset_inpt", inpt, 4'h0);
    check("mid_reset_busy", 4'(busy), 4'h0);
    step();
    check("restart_busy", 4'(busy), 4'h1);
    tick_n(1, 1);
    check("restart_tick1", inpt, 4'h0);
    tick_n(1, 1);
    check("restart_tick2", inpt, 4'hF);
    check("restart_busy_end", 4'(busy), 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
